// File: rtl/adder_128b_registered_if.sv
// rtl/adder_128b_registered_if.sv - operand/result bundle for the registered wide adder
//
// Signals:
//   in0, in1 : WIDTH-bit unsigned operands (driven by master)
//   out0     : WIDTH-bit registered sum (driven by slave)
//   out1     : registered carry-out, sum bit WIDTH (driven by slave)
// Modports:
//   master : drives operands, observes result
//   slave  : observes operands, drives result
interface adder_128b_registered_if #(
    parameter int WIDTH = 128
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out0;
    logic             out1;

    modport master (
        output in0,
        output in1,
        input  out0,
        input  out1
    );

    modport slave (
        input  in0,
        input  in1,
        output out0,
        output out1
    );
endinterface

// File: rtl/adder_128b_registered.sv
// rtl/adder_128b_registered.sv - registered WIDTH-bit unsigned carry-select adder with carry-out
//
// Ports:
//   clk : system clock, all state updates on rising edge
//   rst : asynchronous active-high reset, clears the result register
//   bus : adder_128b_registered_if.slave
//         in0/in1 operands in, out0 = registered sum[WIDTH-1:0], out1 = registered sum[WIDTH]
// Result {out1,out0} = in0 + in1 appears one rising edge after the operands are presented.
// WIDTH must be a multiple of SEG, and SEG a multiple of 4 (lookahead group size).
module adder_128b_registered #(
    parameter int WIDTH = 128,
    parameter int SEG   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    adder_128b_registered_if.slave      bus
);

    localparam int NSEG = WIDTH / SEG;

    // One SEG-bit segment built from 4-bit carry-lookahead groups chained
    // group to group. Returns {carry_out, sum}.
    function automatic logic [SEG:0] cla_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] s;
        logic [SEG:0]   c;
        logic           grp_g;
        logic           grp_p;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i += 4) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            c[i+2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & c[i]);
            c[i+3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i])
                   | (p[i+2] & p[i+1] & p[i] & c[i]);
            // Group generate/propagate give the group carry-out directly
            // from the group carry-in rather than through c[i+3].
            grp_g  = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
                   | (p[i+3] & p[i+2] & p[i+1] & g[i]);
            grp_p  = p[i+3] & p[i+2] & p[i+1] & p[i];
            c[i+4] = grp_g | (grp_p & c[i]);
        end
        s = p ^ c[SEG-1:0];
        return {c[SEG], s};
    endfunction

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Carry-select datapath: segment 0 is a plain add; every higher segment
    // computes both carry-in cases in parallel and the lower segment's
    // carry picks one, so only the mux chain is serial across segments.
    always_comb begin
        logic           carry;
        logic [SEG:0]   res0;
        logic [SEG:0]   res1;
        carry  = 1'b0;
        res0   = '0;
        res1   = '0;
        sum_d  = '0;
        {carry, sum_d[SEG-1:0]} = {1'b0, bus.in0[SEG-1:0]} + {1'b0, bus.in1[SEG-1:0]};
        for (int s = 1; s < NSEG; s++) begin
            res0 = cla_add(bus.in0[s*SEG +: SEG], bus.in1[s*SEG +: SEG], 1'b0);
            res1 = cla_add(bus.in0[s*SEG +: SEG], bus.in1[s*SEG +: SEG], 1'b1);
            {carry, sum_d[s*SEG +: SEG]} = carry ? res1 : res0;
        end
        cout_d = carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.out0 = sum_q;
    assign bus.out1 = cout_q;

endmodule

// File: tb/tb_adder_128b_registered.sv
// tb/tb_adder_128b_registered.sv - self-checking bench for adder_128b_registered
module tb_adder_128b_registered;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    adder_128b_registered_if #(.WIDTH(128)) bus ();

    adder_128b_registered #(.WIDTH(128), .SEG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: the 129-bit arithmetic sum of the operands seen at each
    // rising edge, cleared whenever reset is high.
    logic [128:0] exp_q;
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= '0;
        else     exp_q <= {1'b0, bus.in0} + {1'b0, bus.in1};
    end

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        n_tests++;
        if ({bus.out1, bus.out0} !== exp_q) begin
            n_fail++;
            $display("FAIL stream t=%0t: got %h want %h", $time, {bus.out1, bus.out0}, exp_q);
        end
    end

    // Hand-computed expectation, checked against both DUT and model.
    task automatic lit(input string name, input logic [128:0] want);
        n_tests++;
        if ({bus.out1, bus.out0} !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, {bus.out1, bus.out0}, want);
        end
        n_tests++;
        if (exp_q !== want) begin
            n_fail++;
            $display("FAIL %s_model: got %h want %h", name, exp_q, want);
        end
    endtask

    // Called right after a falling edge: present operands, let one rising
    // edge capture them, return at the following falling edge.
    task automatic apply(input logic [127:0] a, input logic [127:0] b);
        bus.in0 = a;
        bus.in1 = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Segments biased toward 0 and all-ones to exercise carry selects.
    function automatic logic [127:0] rnd128();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
                0:       v[k*32 +: 32] = 32'h0000_0000;
                1:       v[k*32 +: 32] = 32'hFFFF_FFFF;
                default: v[k*32 +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    localparam logic [127:0] ONES = {128{1'b1}};

    initial begin
        logic [127:0] a;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.in0 = ONES;
        bus.in1 = ONES;

        @(posedge clk);
        #1 lit("reset_hold", 129'h0);
        @(negedge clk);
        @(posedge clk);
        #1 lit("reset_hold_edge", 129'h0);
        @(negedge clk);

        // Release between edges: nothing changes until the next rising edge.
        rst = 1'b0;
        #1 lit("release_no_change", 129'h0);
        @(posedge clk);
        @(negedge clk);
        lit("release_first", 129'h1_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);

        apply(ONES, 128'h1);
        lit("wrap", 129'h1_00000000_00000000_00000000_00000000);
        apply(128'h0, 128'h0);
        lit("zero", 129'h0);

        apply(128'h00000000_00000000_00000000_FFFFFFFF, 128'h1);
        lit("carry_seg1", 129'h0_00000000_00000000_00000001_00000000);
        apply(128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'h1);
        lit("carry_seg2", 129'h0_00000000_00000001_00000000_00000000);
        apply(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1);
        lit("carry_seg3", 129'h0_00000001_00000000_00000000_00000000);

        apply(ONES, ONES);
        lit("max_sum", 129'h1_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);

        apply(128'h80000000_00000000_00000000_00000000, 128'h80000000_00000000_00000000_00000001);
        lit("msb_carry", 129'h1_00000000_00000000_00000000_00000001);
        apply(128'h12345678_9ABCDEF0_0F0F0F0F_FFFFFFFF, 128'h11111111_11111111_F0F0F0F0_00000001);
        lit("mixed", 129'h0_23456789_ABCDF002_00000000_00000000);

        for (int i = 0; i < 2000; i++) begin
            a = rnd128();
            bus.in0 = a;
            bus.in1 = rnd128();
            if (i == 1000) begin
                // Asynchronous reset between edges while traffic is running.
                @(posedge clk);
                #2 rst = 1'b1;
                #1 lit("reset_mid_async", 129'h0);
                @(negedge clk);
                @(posedge clk);
                #1 lit("reset_mid_hold", 129'h0);
                @(negedge clk);
                rst = 1'b0;
            end
            @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_128b_registered.md
Name: adder_128b_registered

Overview:
- Registered 128-bit unsigned adder with a single carry-out bit.
- Computes {out1,out0} = in0 + in1 as a 129-bit unsigned result, captured in an output register.
- Used as a wide-datapath arithmetic primitive and as an approximate-logic-synthesis benchmark target.
- The concatenation {out1,out0}, read as a 129-bit unsigned integer, is the externally checked quantity.

Parameters:
- WIDTH, 128, operand and sum width. Only 128 is required to be verified.
- SEG, 32, carry-select segment width. WIDTH must be a multiple of SEG.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in0  input  128  operand A, unsigned.
- in1  input  128  operand B, unsigned.
- out0  output  128  registered sum bits [127:0].
- out1  output  1  registered carry-out, i.e. sum bit 128.

Behaviour:
- Reset:
  - While rst=1, out0=0 and out1=0, regardless of clk.
  - Assertion takes effect immediately (asynchronous).
  - Deassertion is sampled at the next rising clk edge; no output change before that edge.
- Latency: 1 cycle.
  - On each rising clk edge with rst=0, out0/out1 load the sum of the in0/in1 values present at that edge.
  - Outputs are stable for the whole following cycle.
- Throughput: one addition per cycle, no stall, no handshake. Inputs may change every cycle.
- Arithmetic:
  - Pure unsigned modular addition; there is no carry-in.
  - out1 = 1 exactly when in0 + in1 >= 2^128.
  - No saturation and no overflow flag beyond out1.
- Datapath structure (mandatory):
  - Four 32-bit segments, carry-select arrangement.
  - Segment 0 is a plain 32-bit add.
  - Segments 1..3 each precompute the sum with carry-in 0 and carry-in 1; the select is the previous segment's carry.
  - Segment carry chains use generate/propagate logic (4-bit lookahead groups).
  - The full path from inputs to the output register fits in one clock period.
- No internal state besides the 129-bit output register. No X propagation: every output bit is defined after reset.
- Reset mid-stream: the in-flight result is discarded and outputs read 0. The first valid result appears one edge after rst deasserts.
- Inputs with X/Z are out of scope.

Test Plan:
- Reset: rst=1 with in0=in1=all-ones -> out0=0, out1=0 immediately and across clock edges. Release rst -> next edge gives out0=0xFFFF...FFFE, out1=1.
- Wrap: in0=2^128-1, in1=1 -> after 1 edge out0=0, out1=1. Then in0=0, in1=0 -> out0=0, out1=0.
- Segment carry ripple: in0=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, in1=1 -> out0=0x00000001_00000000_00000000_00000000, out1=0.
  - Repeat for each 32-bit boundary individually.
- Maximum sum: in0=in1=2^128-1 -> {out1,out0}=2^129-2, i.e. out1=1, out0=0xFFFF...FFFE.
- Back-to-back random: change operands every cycle for 100000 cycles. Compare {out1,out0} printed as a 129-bit decimal against a 129-bit golden sum delayed one cycle -> zero mismatches.
- Reset mid-stream: assert rst asynchronously between edges during random traffic -> outputs go to 0 without waiting for an edge. After release, resume exact matching from the first post-release edge.
